// File: rtl/centronics_rx.sv
`default_nettype none
// ============================================================================
// Module      : centronics_rx
// Description : Printer-side Centronics receiver. Captures PSG port-B bytes on
//               the falling strobe into a small FIFO, drives BUSY and ACK.
// Revision    : 1.0 - initial release
// ============================================================================
module centronics_rx #(
    parameter int DEPTH_LOG2 = 2,
    parameter int ACK_CYCLES = 40
) (
    input  logic                  clk_8,
    input  logic                  reset,
    input  logic [7:0]            pdata,
    input  logic                  pstrobe_n,
    output logic                  busy,
    output logic                  ack_n,
    output logic [7:0]            out_data,
    output logic                  out_available,
    input  logic                  out_strobe,
    output logic                  overflow,
    input  logic                  clr_overflow,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;
    localparam int c_ACK_W = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
    localparam logic [DEPTH_LOG2:0] c_FULL     = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [c_ACK_W-1:0]  c_ACK_LOAD = c_ACK_W'(ACK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_HIGH = 2'd1,
        S_ACK       = 2'd2
    } state_t;

    state_t                r_state, w_state_next;
    logic                  r_strb_s1, r_strb_s2, r_strb_prev;
    logic [7:0]            r_data_s1, r_data_s2;
    logic                  r_ostrb_prev;
    logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr, w_rd_ptr_next;
    logic [DEPTH_LOG2:0]   r_count, w_count_next;
    logic [c_ACK_W-1:0]    r_ack_cnt, w_ack_cnt_next;
    logic                  r_ack_n, w_ack_n_next;
    logic                  r_busy, r_overflow;
    logic [7:0]            r_out_data, w_head_next;
    logic [7:0]            r_mem [c_DEPTH];

    logic w_fall, w_rise, w_pop, w_push_req, w_push, w_drop;

    assign w_fall     = r_strb_prev & ~r_strb_s2;
    assign w_rise     = ~r_strb_prev & r_strb_s2;
    assign w_pop      = out_strobe & ~r_ostrb_prev & (r_count != '0);
    assign w_push_req = (r_state == S_IDLE) & w_fall;
    // A full FIFO still accepts when a pop frees a slot on the same edge
    assign w_push     = w_push_req & ((r_count != c_FULL) | w_pop);
    assign w_drop     = w_push_req & ~w_push;

    assign w_count_next  = r_count + (DEPTH_LOG2+1)'(w_push) - (DEPTH_LOG2+1)'(w_pop);
    assign w_rd_ptr_next = r_rd_ptr + DEPTH_LOG2'(w_pop);
    // Bypass so the head byte is valid on the same edge it is written into an empty slot
    assign w_head_next   = (w_push && (r_wr_ptr == w_rd_ptr_next)) ? r_data_s2
                                                                   : r_mem[w_rd_ptr_next];

    always_comb begin
        w_state_next   = r_state;
        w_ack_cnt_next = r_ack_cnt;
        w_ack_n_next   = r_ack_n;
        case (r_state)
            S_IDLE: begin
                if (w_fall) w_state_next = S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                if (w_rise) begin
                    w_state_next   = S_ACK;
                    w_ack_cnt_next = c_ACK_LOAD;
                    w_ack_n_next   = 1'b0;
                end
            end
            S_ACK: begin
                if (r_ack_cnt == '0) begin
                    w_ack_n_next = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_ack_cnt_next = r_ack_cnt - 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_ack_n_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_8) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_strb_s1    <= 1'b0;
            r_strb_s2    <= 1'b0;
            r_strb_prev  <= 1'b0;
            r_data_s1    <= '0;
            r_data_s2    <= '0;
            r_ostrb_prev <= 1'b1;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_ack_cnt    <= '0;
            r_ack_n      <= 1'b1;
            r_busy       <= 1'b0;
            r_overflow   <= 1'b0;
            r_out_data   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_strb_s1    <= pstrobe_n;
            r_strb_s2    <= r_strb_s1;
            r_strb_prev  <= r_strb_s2;
            r_data_s1    <= pdata;
            r_data_s2    <= r_data_s1;
            r_ostrb_prev <= out_strobe;
            r_wr_ptr     <= r_wr_ptr + DEPTH_LOG2'(w_push);
            r_rd_ptr     <= w_rd_ptr_next;
            r_count      <= w_count_next;
            r_ack_cnt    <= w_ack_cnt_next;
            r_ack_n      <= w_ack_n_next;
            r_busy       <= (w_state_next != S_IDLE) | (w_count_next == c_FULL);
            r_out_data   <= w_head_next;
            if (w_drop)
                r_overflow <= 1'b1;
            else if (clr_overflow)
                r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk_8) begin
        if (w_push) r_mem[r_wr_ptr] <= r_data_s2;
    end

    assign busy          = r_busy;
    assign ack_n         = r_ack_n;
    assign out_data      = r_out_data;
    assign out_available = (r_count != '0);
    assign overflow      = r_overflow;
    assign count         = r_count;

endmodule
`default_nettype wire

// File: tb/tb_centronics_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_centronics_rx
// Description : Scoreboard bench for centronics_rx with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_centronics_rx;

    localparam int DEPTH = 4;
    localparam int ACK   = 40;

    logic       clk_8 = 1'b0;
    logic       reset, pstrobe_n, out_strobe, clr_overflow;
    logic [7:0] pdata, out_data;
    logic       busy, ack_n, out_available, overflow;
    logic [2:0] count;

    centronics_rx #(.DEPTH_LOG2(2), .ACK_CYCLES(ACK)) dut (
        .clk_8(clk_8), .reset(reset), .pdata(pdata), .pstrobe_n(pstrobe_n),
        .busy(busy), .ack_n(ack_n), .out_data(out_data),
        .out_available(out_available), .out_strobe(out_strobe),
        .overflow(overflow), .clr_overflow(clr_overflow), .count(count)
    );

    always #5 clk_8 = ~clk_8;

    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] sbq[$];
    logic       exp_ovf  = 1'b0;
    logic       mon_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a rising reader strobe with data available pops the head on the next edge
    always @(negedge clk_8) begin
        if (!reset && out_strobe && !mon_prev && out_available) begin
            if (sbq.size() == 0) chk("pop_when_model_empty", out_available, 0);
            else                 chk("pop_data", out_data, sbq.pop_front());
        end
        mon_prev = out_strobe;
    end

    task automatic step();
        @(posedge clk_8);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input int extra, input bit pop_cap, input bit clr_cap);
        bit was_empty, accept;
        int n;
        was_empty = (sbq.size() == 0);
        pdata     = d;
        pstrobe_n = 1'b0;
        step();
        step();
        if (was_empty) chk("avail_before_capture", out_available, 0);
        if (pop_cap) out_strobe = 1'b1;
        if (clr_cap) clr_overflow = 1'b1;
        step();
        accept = (sbq.size() < DEPTH);
        if (accept) begin
            sbq.push_back(d);
            if (was_empty) begin
                chk("avail_at_capture", out_available, 1);
                chk("head_at_capture", out_data, d);
            end
            if (clr_cap) exp_ovf = 1'b0;
        end else begin
            exp_ovf = 1'b1;
        end
        out_strobe   = 1'b0;
        clr_overflow = 1'b0;
        chk("busy_capture", busy, 1);
        chk("overflow_capture", overflow, exp_ovf);
        chk("count_capture", count, sbq.size());
        repeat (extra) step();
        pstrobe_n = 1'b1;
        pdata     = 8'($urandom);
        n = 0;
        while (ack_n !== 1'b0 && n < 10) begin step(); n++; end
        chk("ack_start", ack_n, 0);
        if (ack_n === 1'b0) begin
            n = 0;
            while (ack_n === 1'b0 && n < 100) begin step(); n++; end
            chk("ack_width", n, ACK);
        end
        chk("busy_after_ack", busy, sbq.size() == DEPTH);
        chk("count_after_ack", count, sbq.size());
    endtask

    task automatic pop(input int hold);
        out_strobe = 1'b1;
        repeat (hold) step();
        out_strobe = 1'b0;
        step();
        chk("count_pop", count, sbq.size());
        chk("avail_pop", out_available, sbq.size() != 0);
    endtask

    task automatic clear_ovf();
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        exp_ovf = 1'b0;
        chk("overflow_cleared", overflow, 0);
    endtask

    task automatic drain();
        while (sbq.size() != 0) pop(1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; pstrobe_n = 1'b1; pdata = '0; out_strobe = 1'b0; clr_overflow = 1'b0;
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_ack_n", ack_n, 1);
        chk("rst_avail", out_available, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_count", count, 0);
        chk("rst_out_data", out_data, 0);
        reset = 1'b0;
        repeat (3) step();

        // Single byte
        send(8'hA5, 1, 0, 0);
        pop(1);

        // Fill and overflow
        for (int i = 1; i <= 5; i++) send(8'(i), $urandom_range(0, 3), 0, 0);
        drain();
        pop(1);
        clear_ovf();

        // Pointer wrap
        for (int i = 0; i < 10; i++) begin
            send(8'(8'h10 + i), 0, 0, 0);
            chk("wrap_count_le1", count <= 1, 1);
            pop(1);
        end

        // Simultaneous push and pop while full
        for (int i = 0; i < 4; i++) send(8'($urandom), 0, 0, 0);
        send(8'hC3, 0, 1, 0);
        chk("full_pushpop_count", count, 4);
        chk("full_pushpop_ovf", overflow, 0);
        drain();

        // Held strobe pops once; empty pop ignored
        send(8'h11, 0, 0, 0);
        send(8'h22, 0, 0, 0);
        pop(20);
        chk("held_pop_once", count, 1);
        drain();
        pop(2);
        chk("empty_pop_count", count, 0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) != 0) send(8'($urandom), $urandom_range(0, 3), 0, 0);
            else                           pop($urandom_range(1, 3));
        end
        drain();
        clear_ovf();

        // clr_overflow concurrent with an overflow event
        while (sbq.size() < DEPTH) send(8'($urandom), 0, 0, 0);
        send(8'hEE, 0, 0, 1);
        chk("clr_vs_set_ovf", overflow, 1);
        clear_ovf();
        drain();

        // Reset during ACK with strobe held low
        pdata = 8'h3C; pstrobe_n = 1'b0;
        repeat (3) step();
        pstrobe_n = 1'b1;
        n = 0;
        while (ack_n !== 1'b0 && n < 10) begin step(); n++; end
        chk("pre_reset_ack_low", ack_n, 0);
        repeat (5) step();
        pstrobe_n = 1'b0;
        step();
        reset = 1'b1;
        step();
        sbq.delete();
        exp_ovf = 1'b0;
        chk("reset_abort_ack", ack_n, 1);
        chk("reset_count", count, 0);
        chk("reset_busy", busy, 0);
        step();
        reset = 1'b0;
        repeat (10) step();
        chk("no_capture_low_count", count, 0);
        chk("no_capture_low_busy", busy, 0);
        chk("no_capture_low_ack", ack_n, 1);
        pstrobe_n = 1'b1;
        repeat (3) step();
        send(8'h5A, 0, 0, 0);
        pop(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
